cpu_decode_sb: RTL and testbench
================================

Name: cpu_decode_sb

Overview:
Parametrised successor to the single-cycle moxie decode stage. It sits between fetch and execute and adds several things the earlier stage lacked: valid/ready handshakes on both sides, a flush input, an illegal-opcode flag, and a per-register pending-write scoreboard that holds back RAW/WAW hazards. It decodes all three moxie encoding forms and produces one decoded instruction per accepted input, with one cycle of latency.

Parameters:
NREGS, 16, number of architectural registers; must equal 2**RIDX_W
RIDX_W, 4, register index width
OPERAND_W, 32, operand/immediate width; minimum 16
OP_W, 6, width of the internal op code

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_n_i  in  1  asynchronous active-low reset
flush_i  in  1  discard the held and incoming instruction
sb_clear_i  in  1  clear every scoreboard bit (downstream pipeline flush)
in_valid_i  in  1  fetch presents an instruction
in_ready_o  out  1  decode accepts this cycle
opcode_i  in  16  instruction halfword
operand_i  in  OPERAND_W  trailing immediate word from fetch
out_valid_o  out  1  decoded instruction held
out_ready_i  in  1  execute accepts
op_o  out  OP_W  decoded op
riA_o  out  RIDX_W  register A index
riB_o  out  RIDX_W  register B index
rA_re_o  out  1  A read enable
rB_re_o  out  1  B read enable
we_o  out  1  write enable
widx_o  out  RIDX_W  write index
operand_o  out  OPERAND_W  immediate/offset
illegal_o  out  1  op_o is OP_BAD
wb_valid_i  in  1  writeback completes
wb_idx_i  in  RIDX_W  writeback register

Behaviour:
- Reset (async assert, sync deassert assumed upstream): out_valid_o=0, every output register =0, scoreboard =0.
- Form decode:
  - Form 1, opcode_i[15]=0: op from [15:8]; riA=[7:4]; riB=[3:0].
  - Form 2, [15:14]=10: sub-op [13:12] selects INC/DEC/GSR/SSR; riA=[11:8]; operand = zero-extended [7:0].
  - Form 3, [15:14]=11: cond [13:10] selects branch op; operand = sign-extended {[9:0],1'b0}.
  - Form 1 ops with a trailing word (LDI/LDA/STA/JSRA/JMPA/LDO/STO): operand = operand_i.
  - Unlisted encodings: op=OP_BAD, illegal_o=1, no enables set.
- Enables come from a per-op table in the package. widx=riA when we=1.
- Transfer rules:
  - fire_in = in_valid_i & in_ready_o.
  - fire_out = out_valid_o & out_ready_i.
- Hazard: asserted when the incoming instruction hits a busy register. Busy means the register's scoreboard bit is set, or it matches widx_o while out_valid_o & we_o. A hit is any of:
  - a read of a busy riA (rA_re) or riB (rB_re);
  - a write to a busy widx.
  - Registered scoreboard only; there is no same-cycle writeback bypass.
- Ready: in_ready_o = (!out_valid_o | out_ready_i) & !hazard & !flush_i.
- Output register loads on fire_in. out_valid_o clears on fire_out without fire_in, or on flush_i.
- Latency: one cycle from fire_in to out_valid_o. Back-to-back throughput is one per cycle when there is no hazard.
- Scoreboard update, per bit:
  - Set on fire_out & we_o at widx_o.
  - Cleared on wb_valid_i at wb_idx_i.
  - Set and clear on the same index in the same cycle: the set wins (new writer).
  - sb_clear_i clears all bits and has priority over the set.
- Flush:
  - flush_i drops the held instruction and does not set the scoreboard, even if out_ready_i is high in that cycle.
  - flush_i and sb_clear_i are independent inputs.
- Outputs are stable while out_valid_o & !out_ready_i; the held instruction must not change.
- OP_BAD passes downstream like any other op (so execute can trap) and never sets the scoreboard.

Decomposition:
- Package cpu_decode_pkg holds:
  - the OP_* constants (OP_W wide);
  - the form-select constants;
  - the op-to-{rA_re, rB_re, we, has_operand} table function.
- One sub-module, cpu_scoreboard, containing:
  - NREGS pending bits;
  - set port, clear port and clear-all input;
  - a combinational busy vector output.

Test Plan:
- Reset then opcode 0x0512 (ADD r1,r2) with out_ready=1:
  - out_valid rises one cycle later with op=OP_ADD_L, riA=1, riB=2, rA_re=rB_re=we=1.
  - Scoreboard bit1 sets on fire_out.
- Issue ADD r1,r2, then immediately 0x0231 (MOV r3,r1):
  - in_ready stays 0 until wb_valid=1, wb_idx=1 has been registered.
  - MOV is then accepted the next cycle.
- out_ready held 0 for 5 cycles with LDI_L r4, operand 0xDEADBEEF held:
  - outputs stay constant and in_ready=0;
  - one transfer occurs after out_ready goes to 1.
- Branch 0xC3FF (BEQ, offset field 0x3FF): op=OP_BEQ, operand=0xFFFFFFFE.
- Opcode 0x0F00: op=OP_BAD, illegal_o=1, we=0, and the scoreboard is unchanged.
- Further cases:
  - flush_i asserted while an ADD r5 is held with out_ready=1: out_valid drops and bit5 is not set.
  - Set and wb on the same index in the same cycle: the bit stays 1.
  - rst_n_i asserted mid-stall: all outputs are 0 immediately.

Source files
------------

// File: rtl/cpu_decode_pkg.sv
// Shared decode constants for the moxie decode stage: internal op codes,
// encoding-form selection and the per-op register/operand enable table.
package cpu_decode_pkg;

    localparam int OPC_W = 6;
    typedef logic [OPC_W-1:0] op_t;

    // Form-1 ops keep their moxie major opcode; forms 2/3 live above 0x2F.
    localparam op_t OP_BAD   = 6'h00;
    localparam op_t OP_LDI_L = 6'h01;
    localparam op_t OP_MOV   = 6'h02;
    localparam op_t OP_JSRA  = 6'h03;
    localparam op_t OP_RET   = 6'h04;
    localparam op_t OP_ADD_L = 6'h05;
    localparam op_t OP_LDA_L = 6'h08;
    localparam op_t OP_STA_L = 6'h09;
    localparam op_t OP_LD_L  = 6'h0A;
    localparam op_t OP_ST_L  = 6'h0B;
    localparam op_t OP_LDO_L = 6'h0C;
    localparam op_t OP_STO_L = 6'h0D;
    localparam op_t OP_CMP   = 6'h0E;
    localparam op_t OP_JMPA  = 6'h1A;
    localparam op_t OP_AND   = 6'h26;
    localparam op_t OP_SUB_L = 6'h29;
    localparam op_t OP_OR    = 6'h2B;
    localparam op_t OP_XOR   = 6'h2E;
    localparam op_t OP_INC   = 6'h30;
    localparam op_t OP_DEC   = 6'h31;
    localparam op_t OP_GSR   = 6'h32;
    localparam op_t OP_SSR   = 6'h33;
    localparam op_t OP_BEQ   = 6'h34;
    localparam op_t OP_BLEU  = 6'h3D;
    localparam int  NUM_COND = 10;

    typedef enum logic [1:0] {
        FORM_1 = 2'b00,
        FORM_2 = 2'b10,
        FORM_3 = 2'b11
    } form_e;

    typedef struct packed {
        logic ra_re;
        logic rb_re;
        logic we;
        logic has_operand;
    } op_en_t;

    function automatic form_e form_of(input logic [1:0] hi);
        if (!hi[1]) return FORM_1;
        if (!hi[0]) return FORM_2;
        return FORM_3;
    endfunction

    function automatic op_t f1_op(input logic [6:0] code);
        op_t op;
        op = OP_BAD;
        case (code)
            7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h08, 7'h09, 7'h0A, 7'h0B,
            7'h0C, 7'h0D, 7'h0E, 7'h1A, 7'h26, 7'h29, 7'h2B, 7'h2E: op = code[5:0];
            default: op = OP_BAD;
        endcase
        return op;
    endfunction

    function automatic op_en_t op_en(input op_t op);
        op_en_t e;
        e = '0;
        case (op)
            OP_LDI_L, OP_LDA_L:                      e = '{1'b0, 1'b0, 1'b1, 1'b1};
            OP_MOV, OP_LD_L:                         e = '{1'b0, 1'b1, 1'b1, 1'b0};
            OP_JSRA, OP_JMPA:                        e = '{1'b0, 1'b0, 1'b0, 1'b1};
            OP_ADD_L, OP_AND, OP_SUB_L, OP_OR, OP_XOR: e = '{1'b1, 1'b1, 1'b1, 1'b0};
            OP_STA_L:                                e = '{1'b1, 1'b0, 1'b0, 1'b1};
            OP_ST_L, OP_CMP:                         e = '{1'b1, 1'b1, 1'b0, 1'b0};
            OP_LDO_L:                                e = '{1'b0, 1'b1, 1'b1, 1'b1};
            OP_STO_L:                                e = '{1'b1, 1'b1, 1'b0, 1'b1};
            OP_INC, OP_DEC:                          e = '{1'b1, 1'b0, 1'b1, 1'b0};
            OP_GSR:                                  e = '{1'b0, 1'b0, 1'b1, 1'b0};
            OP_SSR:                                  e = '{1'b1, 1'b0, 1'b0, 1'b0};
            default:                                 e = '0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/cpu_scoreboard.sv
// Pending-write scoreboard: one bit per register, set when a writer leaves
// decode, cleared by writeback or by a downstream flush.
module cpu_scoreboard #(
    parameter int NREGS  = 16,
    parameter int RIDX_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              set_en,
    input  logic [RIDX_W-1:0] set_idx,
    input  logic              clr_en,
    input  logic [RIDX_W-1:0] clr_idx,
    input  logic              clr_all,
    output logic [NREGS-1:0]  busy
);

    logic [NREGS-1:0] pend, pend_nxt;

    // A new writer outranks the retiring one; a pipeline flush outranks both.
    always_comb begin
        pend_nxt = pend;
        if (clr_en)  pend_nxt[clr_idx] = 1'b0;
        if (set_en)  pend_nxt[set_idx] = 1'b1;
        if (clr_all) pend_nxt = '0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) pend <= '0;
        else          pend <= pend_nxt;
    end

    assign busy = pend;

endmodule

// File: rtl/cpu_decode_sb.sv
// Moxie decode stage with valid/ready on both sides, flush, illegal-op flag
// and a scoreboard that stalls RAW/WAW hazards. One cycle of latency.
module cpu_decode_sb
    import cpu_decode_pkg::*;
#(
    parameter int NREGS     = 16,
    parameter int RIDX_W    = 4,
    parameter int OPERAND_W = 32,
    parameter int OP_W      = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 flush_i,
    input  logic                 sb_clear_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [15:0]          opcode_i,
    input  logic [OPERAND_W-1:0] operand_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [OP_W-1:0]      op_o,
    output logic [RIDX_W-1:0]    riA_o,
    output logic [RIDX_W-1:0]    riB_o,
    output logic                 rA_re_o,
    output logic                 rB_re_o,
    output logic                 we_o,
    output logic [RIDX_W-1:0]    widx_o,
    output logic [OPERAND_W-1:0] operand_o,
    output logic                 illegal_o,
    input  logic                 wb_valid_i,
    input  logic [RIDX_W-1:0]    wb_idx_i
);

    op_t                  d_op;
    op_en_t               d_en;
    logic [RIDX_W-1:0]    d_ria, d_rib;
    logic [OPERAND_W-1:0] d_operand;
    logic [NREGS-1:0]     sb_busy, busy;
    logic                 hazard, fire_in, fire_out;

    always_comb begin
        d_op      = OP_BAD;
        d_ria     = '0;
        d_rib     = '0;
        d_operand = '0;
        case (form_of(opcode_i[15:14]))
            FORM_1: begin
                d_op  = f1_op(opcode_i[14:8]);
                d_ria = RIDX_W'(opcode_i[7:4]);
                d_rib = RIDX_W'(opcode_i[3:0]);
                if (op_en(d_op).has_operand) d_operand = operand_i;
            end
            FORM_2: begin
                d_op      = OP_INC + op_t'(opcode_i[13:12]);
                d_ria     = RIDX_W'(opcode_i[11:8]);
                d_operand = OPERAND_W'(opcode_i[7:0]);
            end
            FORM_3: begin
                if (int'(opcode_i[13:10]) < NUM_COND) d_op = OP_BEQ + op_t'(opcode_i[13:10]);
                d_operand = {{(OPERAND_W-11){opcode_i[9]}}, opcode_i[9:0], 1'b0};
            end
            default: d_op = OP_BAD;
        endcase
        d_en = op_en(d_op);
    end

    // The held writer counts as busy before it reaches the scoreboard.
    always_comb begin
        busy = sb_busy;
        if (out_valid_o && we_o) busy[widx_o] = 1'b1;
    end

    assign hazard = (d_en.ra_re & busy[d_ria]) | (d_en.rb_re & busy[d_rib])
                  | (d_en.we & busy[d_ria]);

    // Nothing is accepted while reset is held.
    assign in_ready_o = rst_n_i & (!out_valid_o | out_ready_i) & !hazard & !flush_i;
    assign fire_in    = in_valid_i & in_ready_o;
    assign fire_out   = out_valid_o & out_ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_valid_o <= 1'b0;
            op_o        <= '0;
            riA_o       <= '0;
            riB_o       <= '0;
            rA_re_o     <= 1'b0;
            rB_re_o     <= 1'b0;
            we_o        <= 1'b0;
            widx_o      <= '0;
            operand_o   <= '0;
            illegal_o   <= 1'b0;
        end else begin
            if (flush_i)       out_valid_o <= 1'b0;
            else if (fire_in)  out_valid_o <= 1'b1;
            else if (fire_out) out_valid_o <= 1'b0;
            if (fire_in) begin
                op_o      <= OP_W'(d_op);
                riA_o     <= d_ria;
                riB_o     <= d_rib;
                rA_re_o   <= d_en.ra_re;
                rB_re_o   <= d_en.rb_re;
                we_o      <= d_en.we;
                widx_o    <= d_en.we ? d_ria : '0;
                operand_o <= d_operand;
                illegal_o <= (d_op == OP_BAD);
            end
        end
    end

    cpu_scoreboard #(
        .NREGS  (NREGS),
        .RIDX_W (RIDX_W)
    ) u_sb (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .set_en  (fire_out & we_o & !flush_i),
        .set_idx (widx_o),
        .clr_en  (wb_valid_i),
        .clr_idx (wb_idx_i),
        .clr_all (sb_clear_i),
        .busy    (sb_busy)
    );

endmodule

// File: tb/tb_cpu_decode_sb.sv
// Directed bench for cpu_decode_sb: decode forms, handshake, hazards,
// scoreboard set/clear priorities, flush and asynchronous reset.
module tb_cpu_decode_sb;

    logic        clk_i = 1'b0;
    logic        rst_n_i, flush_i, sb_clear_i, in_valid_i, in_ready_o;
    logic [15:0] opcode_i;
    logic [31:0] operand_i, operand_o;
    logic        out_valid_o, out_ready_i, rA_re_o, rB_re_o, we_o, illegal_o, wb_valid_i;
    logic [5:0]  op_o;
    logic [3:0]  riA_o, riB_o, widx_o, wb_idx_i;

    int n_chk  = 0;
    int n_fail = 0;

    cpu_decode_sb dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i), .sb_clear_i(sb_clear_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .opcode_i(opcode_i),
        .operand_i(operand_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .op_o(op_o), .riA_o(riA_o), .riB_o(riB_o), .rA_re_o(rA_re_o), .rB_re_o(rB_re_o),
        .we_o(we_o), .widx_o(widx_o), .operand_o(operand_o), .illegal_o(illegal_o),
        .wb_valid_i(wb_valid_i), .wb_idx_i(wb_idx_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change 2 time units after the edge; checks run 1 unit later.
    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic chk_out(input string tag, input logic [5:0] op, input logic [3:0] ra,
                           input logic [3:0] rb, input logic [2:0] en, input logic [3:0] wi,
                           input logic [31:0] opd, input logic ill);
        chk({tag, ".valid"},   64'(out_valid_o), 64'(1));
        chk({tag, ".op"},      64'(op_o), 64'(op));
        chk({tag, ".riA"},     64'(riA_o), 64'(ra));
        chk({tag, ".riB"},     64'(riB_o), 64'(rb));
        chk({tag, ".en"},      64'({rA_re_o, rB_re_o, we_o}), 64'(en));
        chk({tag, ".widx"},    64'(widx_o), 64'(wi));
        chk({tag, ".operand"}, 64'(operand_o), 64'(opd));
        chk({tag, ".illegal"}, 64'(illegal_o), 64'(ill));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"}, 64'(out_valid_o), 64'(0));
        chk({tag, ".fields"}, {op_o, riA_o, riB_o, widx_o, operand_o}, 64'(0));
        chk({tag, ".flags"}, 64'({rA_re_o, rB_re_o, we_o, illegal_o, in_ready_o}), 64'(0));
    endtask

    initial begin
        rst_n_i = 1'b0; flush_i = 1'b0; sb_clear_i = 1'b0; in_valid_i = 1'b0;
        opcode_i = '0; operand_i = '0; out_ready_i = 1'b0; wb_valid_i = 1'b0; wb_idx_i = '0;
        tick(); tick(); #1;
        chk_zero("reset");
        rst_n_i = 1'b1;

        // ADD r1,r2 then MOV r3,r1 (RAW on r1)
        tick();
        out_ready_i = 1'b1; in_valid_i = 1'b1; opcode_i = 16'h0512; #1;
        chk("add.in_ready", 64'(in_ready_o), 64'(1));
        tick();
        in_valid_i = 1'b0; #1;
        chk_out("add", 6'h05, 4'd1, 4'd2, 3'b111, 4'd1, 32'h0, 1'b0);
        opcode_i = 16'h0231; in_valid_i = 1'b1; #1;
        chk("mov.hz_held", 64'(in_ready_o), 64'(0));
        tick(); #1;
        chk("add.drained", 64'(out_valid_o), 64'(0));
        chk("mov.hz_sb", 64'(in_ready_o), 64'(0));
        tick(); tick(); #1;
        chk("mov.hz_sb2", 64'(in_ready_o), 64'(0));
        wb_valid_i = 1'b1; wb_idx_i = 4'd1; #1;
        chk("mov.no_bypass", 64'(in_ready_o), 64'(0));
        tick();
        wb_valid_i = 1'b0; #1;
        chk("mov.ready", 64'(in_ready_o), 64'(1));
        tick();
        in_valid_i = 1'b0; #1;
        chk_out("mov", 6'h02, 4'd3, 4'd1, 3'b011, 4'd3, 32'h0, 1'b0);
        tick();
        wb_valid_i = 1'b1; wb_idx_i = 4'd3;
        tick();
        wb_valid_i = 1'b0;

        // LDI_L r4 stalled five cycles by execute
        out_ready_i = 1'b0; in_valid_i = 1'b1; opcode_i = 16'h0140; operand_i = 32'hDEADBEEF;
        tick();
        opcode_i = 16'h0567; operand_i = 32'h12345678;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk_out("ldi.stall", 6'h01, 4'd4, 4'd0, 3'b001, 4'd4, 32'hDEADBEEF, 1'b0);
            chk("ldi.in_ready", 64'(in_ready_o), 64'(0));
            tick();
        end
        in_valid_i = 1'b0; out_ready_i = 1'b1;
        tick(); #1;
        chk("ldi.one_xfer", 64'(out_valid_o), 64'(0));
        opcode_i = 16'h0545; #1;
        chk("ldi.sb_set", 64'(in_ready_o), 64'(0));
        sb_clear_i = 1'b1;
        tick();
        sb_clear_i = 1'b0; #1;
        chk("sb_clear", 64'(in_ready_o), 64'(1));

        // BEQ with the most negative-looking offset field
        in_valid_i = 1'b1; opcode_i = 16'hC3FF;
        tick();
        in_valid_i = 1'b0; #1;
        chk_out("beq", 6'h34, 4'd0, 4'd0, 3'b000, 4'd0, 32'hFFFFFFFE, 1'b0);

        // Form 2 DEC r9,0x80 (zero-extended immediate)
        in_valid_i = 1'b1; opcode_i = 16'h9980;
        tick();
        in_valid_i = 1'b0; #1;
        chk_out("dec", 6'h31, 4'd9, 4'd0, 3'b101, 4'd9, 32'h80, 1'b0);
        tick();
        sb_clear_i = 1'b1;
        tick();
        sb_clear_i = 1'b0;

        // Unlisted encoding 0x0F00
        in_valid_i = 1'b1; opcode_i = 16'h0F00;
        tick();
        in_valid_i = 1'b0; #1;
        chk_out("bad", 6'h00, 4'd0, 4'd0, 3'b000, 4'd0, 32'h0, 1'b1);
        tick();
        opcode_i = 16'h0500; #1;
        chk("bad.sb_clean", 64'(in_ready_o), 64'(1));

        // Flush while ADD r5,r6 is being taken by execute
        in_valid_i = 1'b1; opcode_i = 16'h0556;
        tick();
        in_valid_i = 1'b0; flush_i = 1'b1; #1;
        chk("flush.in_ready", 64'(in_ready_o), 64'(0));
        tick();
        flush_i = 1'b0; opcode_i = 16'h0505; #1;
        chk("flush.valid", 64'(out_valid_o), 64'(0));
        chk("flush.no_set", 64'(in_ready_o), 64'(1));

        // ADD r7,r1 leaves decode in the same cycle r7 writes back
        in_valid_i = 1'b1; opcode_i = 16'h0571;
        tick();
        in_valid_i = 1'b0; wb_valid_i = 1'b1; wb_idx_i = 4'd7;
        tick();
        wb_valid_i = 1'b0; opcode_i = 16'h0507; #1;
        chk("setwins.busy", 64'(in_ready_o), 64'(0));
        wb_valid_i = 1'b1;
        tick();
        wb_valid_i = 1'b0; #1;
        chk("setwins.wb", 64'(in_ready_o), 64'(1));

        // Asynchronous reset mid-stall
        out_ready_i = 1'b0; in_valid_i = 1'b1; opcode_i = 16'h0523;
        tick();
        in_valid_i = 1'b0; #1;
        chk("rst.held", 64'(out_valid_o), 64'(1));
        rst_n_i = 1'b0; #1;
        chk_zero("rst.async");
        tick();
        rst_n_i = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
